// File: rtl/ha3_pkg.sv
// Shared definitions for the ha3 divider family: default operand width and
// the handshake FSM state encoding.
package ha3_pkg;

    localparam int HA3_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } ha3_state_e;

endpackage

// File: rtl/ha3_shift_add.sv
// Unsigned WIDTH x WIDTH iterative multiplier: one partial product per step,
// multiplicand shifted right, multiplier shifted left by the step count.
module ha3_shift_add
    import ha3_pkg::*;
#(
    parameter int WIDTH = HA3_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   acc_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q,    cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            cnt_d    = '0;
        end else if (step_i) begin
            if (mcand_q[0]) begin
                acc_d = acc_q + ({{WIDTH{1'b0}}, mplier_q} << cnt_q);
            end
            mcand_d = mcand_q >> 1;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // High during the final iteration, so the controller can leave MUL on the same edge.
    assign done_o = (cnt_q == CW'(WIDTH - 1));
    assign acc_o  = acc_q;

endmodule

// File: rtl/ha3_mul_add.sv
// Rebuilds A = Q*D + R (signed) using the ha3 REQ/ACK handshake; the inverse of
// the ha3 divider. Sign/magnitude around an unsigned shift-add core.
module ha3_mul_add
    import ha3_pkg::*;
#(
    parameter int WIDTH = HA3_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] r_i,
    output logic             ack_o,
    output logic [WIDTH-1:0] a_o,
    output logic             ovf_o
);

    ha3_state_e         state_q;
    logic               sign_q;
    logic               ack_q;
    logic               ovf_q;
    logic               armed_q;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   a_q;

    logic               start;
    logic               step;
    logic               core_done;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   d_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] sum;
    logic               ovf_fix;

    assign start = (state_q == IDLE) && req_i && armed_q;
    assign step  = (state_q == MUL);

    // Most-negative input maps to 2^(WIDTH-1), which still fits unsigned.
    assign q_mag = q_i[WIDTH-1] ? (~q_i + 1'b1) : q_i;
    assign d_mag = d_i[WIDTH-1] ? (~d_i + 1'b1) : d_i;

    ha3_shift_add #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .step_i   (step),
        .mcand_i  (q_mag),
        .mplier_i (d_mag),
        .done_o   (core_done),
        .acc_o    (acc)
    );

    assign prod    = sign_q ? (~acc + 1'b1) : acc;
    assign sum     = prod + {{WIDTH{r_q[WIDTH-1]}}, r_q};
    assign ovf_fix = ~((&sum[2*WIDTH-1:WIDTH-1]) | ~(|sum[2*WIDTH-1:WIDTH-1]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            armed_q <= 1'b1;
            r_q     <= '0;
            a_q     <= '0;
        end else begin
            // Any sampled REQ=0 re-arms; a held-high REQ never retriggers.
            if (!req_i) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q  <= q_i[WIDTH-1] ^ d_i[WIDTH-1];
                        r_q     <= r_i;
                        armed_q <= 1'b0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    if (core_done) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    a_q     <= sum[WIDTH-1:0];
                    ovf_q   <= ovf_fix;
                    ack_q   <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    if (!req_i) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o = ack_q;
    assign a_o   = a_q;
    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_ha3_mul_add.sv
// Self-checking bench for ha3_mul_add: fixed vector table, random vectors and
// divide round trips against an integer model, plus handshake/reset sequences.
module tb_ha3_mul_add;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic [15:0] q_i;
    logic [15:0] d_i;
    logic [15:0] r_i;
    logic        ack_o;
    logic [15:0] a_o;
    logic        ovf_o;

    int checks   = 0;
    int failures = 0;

    ha3_mul_add #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req_i),
        .q_i   (q_i),
        .d_i   (d_i),
        .r_i   (r_i),
        .ack_o (ack_o),
        .a_o   (a_o),
        .ovf_o (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [15:0] d;
        logic [15:0] r;
        logic [15:0] a;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [15:0] q, input logic [15:0] d, input logic [15:0] r,
                                  output logic [15:0] a, output logic ovf);
        longint s;
        s   = longint'($signed(q)) * longint'($signed(d)) + longint'($signed(r));
        a   = s[15:0];
        ovf = (s > 32767) || (s < -32768);
    endfunction

    // REQ must already be high; consumes the accept edge, then counts edges until ACK.
    task automatic wait_ack(output int lat);
        lat = -1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (ack_o) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_txn(input string name, input logic [15:0] q, input logic [15:0] d,
                           input logic [15:0] r, input logic [15:0] ea, input logic eovf);
        int lat;
        @(negedge clk);
        q_i = q; d_i = d; r_i = r; req_i = 1'b1;
        wait_ack(lat);
        chk({name, "_lat"}, lat, 17);
        chk({name, "_a"}, a_o, ea);
        chk({name, "_ovf"}, ovf_o, eovf);
        @(negedge clk);
        req_i = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_ackfall"}, ack_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ea;
        logic        eovf;
        int          lat;

        vecs[0] = '{16'h0007, 16'h0003, 16'h0002, 16'h0017, 1'b0};
        vecs[1] = '{16'hFFFB, 16'h0004, 16'h0003, 16'hFFEF, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0002, 16'h0000, 16'hFFFE, 1'b1};
        vecs[3] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b1};
        vecs[4] = '{16'd1234, 16'h0000, 16'h0005, 16'h0005, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 16'h0000, 16'h8000, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b1};
        vecs[8] = '{16'h8000, 16'h0001, 16'hFFFF, 16'h7FFF, 1'b1};
        vecs[9] = '{16'h0000, 16'h8000, 16'h8000, 16'h8000, 1'b0};

        rst_n = 1'b0; req_i = 1'b0; q_i = '0; d_i = '0; r_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", ack_o, 0);
        chk("reset_a", a_o, 0);
        chk("reset_ovf", ovf_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].q, vecs[i].d, vecs[i].r, vecs[i].a, vecs[i].ovf);
        end

        for (int i = 0; i < 20; i++) begin
            logic [15:0] q, d, r;
            q = 16'($urandom); d = 16'($urandom); r = 16'($urandom);
            model(q, d, r, ea, eovf);
            run_txn($sformatf("rand%0d", i), q, d, r, ea, eovf);
        end

        for (int i = 0; i < 10; i++) begin
            int a, dv, qv, rv;
            logic [15:0] a16;
            a  = int'($urandom_range(0, 65535)) - 32768;
            dv = int'($urandom_range(0, 65535)) - 32768;
            if (dv == 0 || (a == -32768 && dv == -1)) dv = 7;
            qv = a / dv;
            rv = a % dv;
            a16 = a[15:0];
            run_txn($sformatf("trip%0d", i), qv[15:0], dv[15:0], rv[15:0], a16, 1'b0);
        end

        // Reset in the middle of MUL, then a full run with REQ held through release.
        run_txn("pre_rst", 16'h0007, 16'h0003, 16'h0002, 16'h0017, 1'b0);
        @(negedge clk);
        q_i = 16'd100; d_i = 16'hFFFD; r_i = 16'd7; req_i = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", ack_o, 0);
        chk("midrst_a", a_o, 0);
        chk("midrst_ovf", ovf_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(lat);
        model(16'd100, 16'hFFFD, 16'd7, ea, eovf);
        chk("postrst_lat", lat, 17);
        chk("postrst_a", a_o, ea);
        chk("postrst_ovf", ovf_o, eovf);

        // REQ held after ACK: no recompute even when inputs change.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            q_i = 16'(i + 50); d_i = 16'h0011;
            @(posedge clk);
            #1;
            chk("hold_ack", ack_o, 1);
            chk("hold_a", a_o, ea);
        end
        @(negedge clk);
        req_i = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_ackfall", ack_o, 0);
        @(negedge clk);
        q_i = 16'hFF00; d_i = 16'h0021; r_i = 16'h0013; req_i = 1'b1;
        wait_ack(lat);
        model(16'hFF00, 16'h0021, 16'h0013, ea, eovf);
        chk("rearm_lat", lat, 17);
        chk("rearm_a", a_o, ea);
        chk("rearm_ovf", ovf_o, eovf);
        @(negedge clk);
        req_i = 1'b0;
        @(posedge clk);

        // REQ dropped during MUL: result still delivered, ACK lasts one cycle.
        @(negedge clk);
        q_i = 16'h1234; d_i = 16'hFFF0; r_i = 16'h0042; req_i = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        req_i = 1'b0;
        lat = -1;
        for (int n = 6; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (ack_o) begin
                lat = n;
                break;
            end
        end
        model(16'h1234, 16'hFFF0, 16'h0042, ea, eovf);
        chk("drop_lat", lat, 17);
        chk("drop_a", a_o, ea);
        chk("drop_ovf", ovf_o, eovf);
        @(posedge clk);
        #1;
        chk("drop_ack_pulse", ack_o, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_no_retrig", ack_o, 0);
        chk("drop_a_kept", a_o, ea);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
